// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths and port identifiers for the data-memory arbiter
package dmem_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int OWNER_W = 1;
  localparam int CNT_W = 8;
  localparam logic [OWNER_W-1:0] PORT_CPU = 1'b0;
  localparam logic [OWNER_W-1:0] PORT_LDR = 1'b1;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating wait counter that flags when the loader must be forced
module arb_starve_ctr import dmem_pkg::*; #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && r_cnt != LIM) r_cnt <= r_cnt + 1'b1;
  assign o_at_limit = r_cnt == LIM;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU-priority arbiter for a single-port data memory with a
// starvation limiter for the loader port and an in-order read return path
module dmem_arbiter import dmem_pkg::*; #(
  parameter int ADDR_W       = dmem_pkg::ADDR_W,
  parameter int DATA_W       = dmem_pkg::DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic               w_at_limit;
  logic               w_forced;
  logic               r_pending;
  logic [OWNER_W-1:0] r_owner;

  arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_inc      (m1_req & m0_gnt),
    .i_clr      (m1_gnt | ~m1_req),
    .o_at_limit (w_at_limit)
  );

  // grants are held low throughout reset even though requests pass through
  assign w_forced  = m1_req & w_at_limit;
  assign m1_gnt    = reset & (w_forced | (m1_req & ~m0_req));
  assign m0_gnt    = reset & m0_req & ~w_forced;
  assign cpu_stall = m0_req & ~m0_gnt;

  always_comb begin
    mem_en    = m0_gnt | m1_gnt;
    mem_we    = m0_gnt ? m0_we    : m1_gnt ? m1_we    : 1'b0;
    mem_addr  = m0_gnt ? m0_addr  : m1_gnt ? m1_addr  : '0;
    mem_wdata = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_pending <= 1'b0;
      r_owner   <= PORT_CPU;
    end else begin
      r_pending <= mem_en & ~mem_we;
      if (mem_en & ~mem_we) r_owner <= m1_gnt ? PORT_LDR : PORT_CPU;
    end

  assign m0_rvalid = r_pending & (r_owner == PORT_CPU);
  assign m1_rvalid = r_pending & (r_owner == PORT_LDR);
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of grant priority, starvation forcing,
// read return ordering and reset behaviour against a small memory model
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, cpu_stall;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        d1_m0_gnt, d1_m0_rvalid, d1_m1_gnt, d1_m1_rvalid, d1_stall;
  logic [31:0] d1_m0_rdata, d1_m1_rdata;
  logic        d1_en, d1_we;
  logic [31:0] d1_addr, d1_wdata;
  logic [31:0] mem [0:255];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(8)) u_dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .cpu_stall(cpu_stall), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.STARVE_LIMIT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(d1_m0_gnt), .m0_rvalid(d1_m0_rvalid), .m0_rdata(d1_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(d1_m1_gnt), .m1_rvalid(d1_m1_rvalid), .m1_rdata(d1_m1_rdata),
    .cpu_stall(d1_stall), .mem_en(d1_en), .mem_we(d1_we),
    .mem_addr(d1_addr), .mem_wdata(d1_wdata), .mem_rdata(32'h0)
  );

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[9:2]];
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // both ports request continuously from a cleared counter; called just after a negedge
  task automatic contention(input int n);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h44;
    for (int k = 0; k < n; k++) begin
      #1;
      chk($sformatf("cont_m0_gnt[%0d]", k), {31'b0, m0_gnt}, {31'b0, (k % 9) != 8});
      chk($sformatf("cont_m1_gnt[%0d]", k), {31'b0, m1_gnt}, {31'b0, (k % 9) == 8});
      chk($sformatf("cont_stall[%0d]", k), {31'b0, cpu_stall}, {31'b0, (k % 9) == 8});
      chk($sformatf("cont_addr[%0d]", k), mem_addr, ((k % 9) == 8) ? 32'h44 : 32'h40);
      chk($sformatf("lim1_m1_gnt[%0d]", k), {31'b0, d1_m1_gnt}, {31'b0, (k % 2) == 1});
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1] = 32'hA1A1A1A1;
    mem[2] = 32'hB2B2B2B2;
    mem[3] = 32'hC3C3C3C3;
    mem[4] = 32'hDEADBEEF;
    mem_rdata = 32'h0;
    m0_req = 1'b1; m0_addr = 32'h10;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
    chk("rst_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    chk("rst_stall", {31'b0, cpu_stall}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    chk("rel_mem_en", {31'b0, mem_en}, 32'd1);
    chk("rel_mem_addr", mem_addr, 32'h10);
    @(negedge clk);
    m0_req = 1'b0;
    #1;
    chk("rd_m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    chk("idle_mem_en", {31'b0, mem_en}, 32'd0);
    chk("idle_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    contention(18);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h55;
    #1;
    chk("wr_m1_gnt", {31'b0, m1_gnt}, 32'd1);
    chk("wr_mem_we", {31'b0, mem_we}, 32'd1);
    chk("wr_mem_addr", mem_addr, 32'h20);
    chk("wr_mem_wdata", mem_wdata, 32'h55);
    @(negedge clk);
    m1_req = 1'b0; m1_we = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
    #1;
    chk("wr_no_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    chk("rb_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    @(negedge clk);
    m0_req = 1'b0;
    #1;
    chk("rb_m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
    chk("rb_m0_rdata", m0_rdata, 32'h55);
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 32'h4;
    #1;
    chk("alt0_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8;
    #1;
    chk("alt1_m1_gnt", {31'b0, m1_gnt}, 32'd1);
    chk("alt1_m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
    chk("alt1_m0_rdata", m0_rdata, 32'hA1A1A1A1);
    chk("alt1_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    @(negedge clk);
    m1_req = 1'b0; m0_req = 1'b1; m0_addr = 32'hC;
    #1;
    chk("alt2_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    chk("alt2_m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
    chk("alt2_m1_rdata", m1_rdata, 32'hB2B2B2B2);
    chk("alt2_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
    @(negedge clk);
    m0_req = 1'b0;
    #1;
    chk("alt3_m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
    chk("alt3_m0_rdata", m0_rdata, 32'hC3C3C3C3);
    chk("alt3_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    @(negedge clk);
    m1_req = 1'b1; m1_addr = 32'h8;
    #1;
    chk("mid_m1_gnt", {31'b0, m1_gnt}, 32'd1);
    @(negedge clk);
    m1_req = 1'b0; reset = 1'b0;
    #1;
    chk("mid_rst_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rel_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    chk("mid_rel_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
    @(negedge clk);
    #1;
    chk("mid_late_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    @(negedge clk);
    contention(3);
    reset = 1'b0;
    #1;
    chk("cnt_rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    chk("cnt_rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    contention(9);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
